// File: rtl/ac_control_pkg.sv
// ac_control_pkg: opcode and FSM state encodings shared by the accumulator block and its bench
package ac_control_pkg;
   typedef enum logic [2:0] {
      AC_OP_NOP   = 3'd0,
      AC_OP_LOAD  = 3'd1,
      AC_OP_WRALU = 3'd2,
      AC_OP_CLR   = 3'd3,
      AC_OP_INC   = 3'd4,
      AC_OP_DEC   = 3'd5,
      AC_OP_SHL   = 3'd6,
      AC_OP_SHR   = 3'd7
   } ac_op_e;
   typedef enum logic {
      AC_ST_IDLE  = 1'b0,
      AC_ST_SHIFT = 1'b1
   } ac_state_e;
endpackage

// File: rtl/ac_control_if.sv
// ac_control_if: control-unit <-> accumulator request/status bundle
interface ac_control_if
   import ac_control_pkg::*;
#(parameter int WIDTH = 8) ();
   ac_op_e           op;
   logic             op_valid;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] alu_in;
   logic             alu_carry;
   logic [WIDTH-1:0] ac_out;
   logic             zero;
   logic             neg;
   logic             carry;
   logic             busy;
   logic             done;
   modport master (output op, op_valid, data_in, alu_in, alu_carry,
                   input ac_out, zero, neg, carry, busy, done);
   modport slave  (input op, op_valid, data_in, alu_in, alu_carry,
                   output ac_out, zero, neg, carry, busy, done);
endinterface

// File: rtl/ac_shift_step.sv
// ac_shift_step: one-bit left/right shift of the accumulator (dir=1 is right)
// AC_SHIFT_ROTATE_EN defined: rotate; undefined: logical shift with zero fill
module ac_shift_step #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0] value,
   input  logic             dir,
   output logic [WIDTH-1:0] shifted,
   output logic             bit_out
);
   always_comb begin
      bit_out = dir ? value[0] : value[WIDTH-1];
`ifdef AC_SHIFT_ROTATE_EN
      shifted = dir ? {value[0], value[WIDTH-1:1]} : {value[WIDTH-2:0], value[WIDTH-1]};
`else
      shifted = dir ? {1'b0, value[WIDTH-1:1]} : {value[WIDTH-2:0], 1'b0};
`endif
   end
endmodule

// File: rtl/ac_control.sv
// ac_control: accumulator register, flags and bit-serial shift FSM with busy/done handshake
// Shift flavour selected by AC_SHIFT_ROTATE_EN (see ac_shift_step)
module ac_control
   import ac_control_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input logic         clk,
   input logic         rst,
   ac_control_if.slave bus
);
   ac_state_e        state;
   logic [WIDTH-1:0] ac, sh;
   logic [CNT_W-1:0] cnt, n;
   logic             dir, bit_out, c, busy_r, done_r;
   assign n = bus.data_in[CNT_W-1:0];
   ac_shift_step #(.WIDTH(WIDTH)) u_step (.value(ac), .dir(dir), .shifted(sh), .bit_out(bit_out));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= AC_ST_IDLE;
         ac     <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         dir    <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            AC_ST_IDLE: if (bus.op_valid) begin
               case (bus.op)
                  AC_OP_LOAD:  ac <= bus.data_in;
                  AC_OP_WRALU: {c, ac} <= {bus.alu_carry, bus.alu_in};
                  AC_OP_CLR:   {c, ac} <= '0;
                  AC_OP_INC:   {c, ac} <= {1'b0, ac} + {{WIDTH{1'b0}}, 1'b1};
                  AC_OP_DEC:   {c, ac} <= {1'b0, ac} - {{WIDTH{1'b0}}, 1'b1};
                  default:     ;
               endcase
               // zero-length shifts complete like any single-cycle op
               if ((bus.op == AC_OP_SHL || bus.op == AC_OP_SHR) && n != '0) begin
                  state  <= AC_ST_SHIFT;
                  busy_r <= 1'b1;
                  cnt    <= n;
                  dir    <= bus.op == AC_OP_SHR;
               end else
                  done_r <= 1'b1;
            end
            AC_ST_SHIFT: begin
               ac  <= sh;
               c   <= bit_out;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state  <= AC_ST_IDLE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end
            end
            default: state <= AC_ST_IDLE;
         endcase
      end
   end
   assign bus.ac_out = ac;
   assign bus.zero   = ac == '0;
   assign bus.neg    = ac[WIDTH-1];
   assign bus.carry  = c;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
endmodule
